// File: rtl/sr_request_sequencer.sv
// Turns two asynchronous, bouncy request levels into clean, clock-aligned S/R
// pulses for a downstream SR flip-flop, rejecting conflicting requests.
module sr_request_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 1,
  parameter int HOLDOFF_CYCLES  = 2,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic s,
  output logic r,
  output logic busy,
  output logic conflict
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] QUAL = 2'd1;
  localparam logic [1:0] FIRE = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  localparam logic PEND_SET = 1'b0;
  localparam logic PEND_CLR = 1'b1;

  localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

  logic             set_sync1_q, set_sync2_q, set_prev_q;
  logic             clr_sync1_q, clr_sync2_q, clr_prev_q;
  logic [1:0]       state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             busy_q, busy_d;
  logic             conflict_q, conflict_d;

  logic set_edge, clr_edge, pend_lvl, other_edge;

  always_comb begin
    set_edge   = set_sync2_q & ~set_prev_q;
    clr_edge   = clr_sync2_q & ~clr_prev_q;
    pend_lvl   = (pend_q == PEND_CLR) ? clr_sync2_q : set_sync2_q;
    other_edge = (pend_q == PEND_CLR) ? set_edge : clr_edge;

    state_d    = state_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    conflict_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (set_edge && clr_edge) begin
          conflict_d = 1'b1;
        end else if (set_edge) begin
          state_d = QUAL;
          pend_d  = PEND_SET;
          cnt_d   = '0;
        end else if (clr_edge) begin
          state_d = QUAL;
          pend_d  = PEND_CLR;
          cnt_d   = '0;
        end
      end
      QUAL: begin
        // A dropped level is a glitch; a new edge on the other line is a conflict.
        if (!pend_lvl) begin
          state_d = IDLE;
        end else if (other_edge) begin
          state_d    = IDLE;
          conflict_d = 1'b1;
        end else if (cnt_q == DEB_LAST) begin
          state_d = FIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Pulses are registered from the next state so they rise on the edge entering FIRE.
    s_d    = (state_d == FIRE) && (pend_d == PEND_SET);
    r_d    = (state_d == FIRE) && (pend_d == PEND_CLR);
    busy_d = (state_q != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_sync1_q <= 1'b0;
      set_sync2_q <= 1'b0;
      set_prev_q  <= 1'b0;
      clr_sync1_q <= 1'b0;
      clr_sync2_q <= 1'b0;
      clr_prev_q  <= 1'b0;
      state_q     <= IDLE;
      pend_q      <= PEND_SET;
      cnt_q       <= '0;
      s_q         <= 1'b0;
      r_q         <= 1'b0;
      busy_q      <= 1'b0;
      conflict_q  <= 1'b0;
    end else begin
      set_sync1_q <= set_req;
      set_sync2_q <= set_sync1_q;
      set_prev_q  <= set_sync2_q;
      clr_sync1_q <= clr_req;
      clr_sync2_q <= clr_sync1_q;
      clr_prev_q  <= clr_sync2_q;
      state_q     <= state_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      s_q         <= s_d;
      r_q         <= r_d;
      busy_q      <= busy_d;
      conflict_q  <= conflict_d;
    end
  end

  assign s        = s_q;
  assign r        = r_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_request_sequencer.sv
// Directed bench for sr_request_sequencer: default instance plus a PULSE_LEN=3
// instance used for the mid-pulse reset scenario.
module tb_sr_request_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, set_req, clr_req, s, r, busy, conflict;
  logic rst6, set_req6, clr_req6, s6, r6, busy6, conflict6;

  int checks = 0;
  int errors = 0;

  sr_request_sequencer u_dut (
    .clk(clk), .rst(rst), .set_req(set_req), .clr_req(clr_req),
    .s(s), .r(r), .busy(busy), .conflict(conflict)
  );

  sr_request_sequencer #(.PULSE_LEN(3)) u_dut6 (
    .clk(clk), .rst(rst6), .set_req(set_req6), .clr_req(clr_req6),
    .s(s6), .r(r6), .busy(busy6), .conflict(conflict6)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; set_req = 1'b1; clr_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({s, r, busy, conflict} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got {s,r,busy,conflict}=%b want 0000", i, {s, r, busy, conflict});
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if ({s, r, busy} !== 3'b000) begin
        errors++;
        $display("FAIL post_reset_no_pulse cycle %0d got {s,r,busy}=%b want 000", i, {s, r, busy});
      end
    end
    set_req = 1'b0; clr_req = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_single_set();
    set_req = 1'b1;
    for (int i = 0; i < 14; i++) begin
      step();
      checks++;
      if (s !== (i == 6)) begin
        errors++;
        $display("FAIL set_pulse_s cycle %0d got %b want %b", i, s, (i == 6));
      end
      checks++;
      if (busy !== (i >= 3 && i <= 9)) begin
        errors++;
        $display("FAIL set_pulse_busy cycle %0d got %b want %b", i, busy, (i >= 3 && i <= 9));
      end
      checks++;
      if ({r, conflict} !== 2'b00) begin
        errors++;
        $display("FAIL set_pulse_r_conflict cycle %0d got %b want 00", i, {r, conflict});
      end
    end
    set_req = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_short_glitch();
    set_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({s, r, conflict} !== 3'b000) begin
        errors++;
        $display("FAIL glitch_no_pulse cycle %0d got {s,r,conflict}=%b want 000", i, {s, r, conflict});
      end
      if (i == 1) set_req = 1'b0;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_idle got %b want 0", busy);
    end
  endtask

  task automatic test_conflict();
    set_req = 1'b1; clr_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (conflict !== (i == 2)) begin
        errors++;
        $display("FAIL conflict_pulse cycle %0d got %b want %b", i, conflict, (i == 2));
      end
      checks++;
      if ({s, r, busy} !== 3'b000) begin
        errors++;
        $display("FAIL conflict_quiet cycle %0d got {s,r,busy}=%b want 000", i, {s, r, busy});
      end
    end
    set_req = 1'b0; clr_req = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_hold_ignore();
    set_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (s !== (i == 6)) begin
        errors++;
        $display("FAIL hold_set_s cycle %0d got %b want %b", i, s, (i == 6));
      end
      checks++;
      if ({r, conflict} !== 2'b00) begin
        errors++;
        $display("FAIL hold_ignored cycle %0d got {r,conflict}=%b want 00", i, {r, conflict});
      end
      if (i == 6) clr_req = 1'b1;
    end
    clr_req = 1'b0;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_back_idle got %b want 0", busy);
    end
    clr_req = 1'b1;
    for (int j = 0; j < 12; j++) begin
      step();
      checks++;
      if (r !== (j == 6)) begin
        errors++;
        $display("FAIL retrigger_r cycle %0d got %b want %b", j, r, (j == 6));
      end
      checks++;
      if ({s, conflict} !== 2'b00) begin
        errors++;
        $display("FAIL retrigger_s_conflict cycle %0d got %b want 00", j, {s, conflict});
      end
    end
    set_req = 1'b0; clr_req = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset_mid_pulse();
    step();
    checks++;
    if ({s6, r6, busy6, conflict6} !== 4'b0000) begin
      errors++;
      $display("FAIL p3_reset_state got %b want 0000", {s6, r6, busy6, conflict6});
    end
    rst6 = 1'b0;
    repeat (3) step();
    set_req6 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (s6 !== (i >= 6)) begin
        errors++;
        $display("FAIL p3_fire_s cycle %0d got %b want %b", i, s6, (i >= 6));
      end
    end
    rst6 = 1'b1; set_req6 = 1'b0;
    step();
    checks++;
    if ({s6, r6, busy6} !== 3'b000) begin
      errors++;
      $display("FAIL p3_mid_pulse_reset got {s,r,busy}=%b want 000", {s6, r6, busy6});
    end
    rst6 = 1'b0;
    repeat (5) step();
    set_req6 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if (s6 !== (i >= 6 && i <= 8)) begin
        errors++;
        $display("FAIL p3_refire_s cycle %0d got %b want %b", i, s6, (i >= 6 && i <= 8));
      end
      checks++;
      if ({r6, conflict6} !== 2'b00) begin
        errors++;
        $display("FAIL p3_refire_r cycle %0d got %b want 00", i, {r6, conflict6});
      end
    end
    set_req6 = 1'b0;
  endtask

  initial begin
    rst6 = 1'b1; set_req6 = 1'b0; clr_req6 = 1'b0;
    test_reset();
    test_single_set();
    test_short_glitch();
    test_conflict();
    test_hold_ignore();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
